mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-002 MULT_control  input  1  start-multiply request from the control unit, sampled in IDLE only.
REQ-003 DIV_control  input  1  start-divide request from the control unit, sampled in IDLE only.
REQ-004 A  input  32  operand (multiplicand / dividend), captured at the start edge.
REQ-005 B  input  32  operand (multiplier / divisor), captured at the start edge.
REQ-006 HI  output  32  product bits 63:32 / remainder.
REQ-007 LO  output  32  product bits 31:0 / quotient.
REQ-008 multStop  output  1  one-cycle pulse marking multiply complete.
REQ-009 divStop  output  1  one-cycle pulse marking divide complete.
REQ-010 divZero  output  1  one-cycle pulse marking a divide-by-zero abort (see Configuration).

Function
REQ-011 The FSM SHALL have states IDLE, MULT, DIV, FIX, DONE; only IDLE accepts requests.
REQ-012 In IDLE, MULT_control=1 SHALL capture A/B, clear the iteration counter, and enter MULT; MULT_control has priority when both requests are high.
REQ-013 In IDLE, DIV_control=1 (MULT_control=0) SHALL capture |A| and |B| plus both sign bits, and enter DIV.
REQ-014 Requests arriving outside IDLE SHALL be ignored, with no queuing.
REQ-015 MULT SHALL perform signed radix-2 Booth multiplication, one iteration per cycle, on a 65-bit accumulator; after exactly 32 iterations it SHALL enter DONE.
REQ-016 DIV SHALL perform 32 iterations of restoring division on the magnitudes, one per cycle, then enter FIX.
REQ-017 FIX SHALL negate the quotient if the operand signs differ, and negate the remainder if A was negative (the remainder takes the dividend's sign); FIX then enters DONE.
REQ-018 In DONE, HI/LO SHALL update to the result, exactly one of multStop/divStop SHALL be 1 for one cycle, and the next state is IDLE.
REQ-019 Latency SHALL be fixed: multiply stop pulse is 33 cycles after the start edge; divide stop pulse is 34 cycles after the start edge.
REQ-020 HI/LO SHALL hold their values between completions; intermediate iteration values are never visible on HI/LO.
REQ-021 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0 (wrap, no flag).
REQ-022 A request held high across DONE→IDLE SHALL start a new operation on the first IDLE edge.

Reset
REQ-023 Asserting reset SHALL force IDLE and set HI=0, LO=0, multStop=0, divStop=0, divZero=0, and counter=0, including mid-operation; the aborted operation produces no stop pulse.
REQ-024 The first request is accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-025 Macro DIVZERO_EXC_EN SHALL control divide-by-zero handling.
REQ-026 With DIVZERO_EXC_EN defined: DIV_control with B=0 in IDLE SHALL go directly to DONE; divZero=1 and divStop=1 in that cycle; HI/LO are unchanged; latency is 1 cycle.
REQ-027 Without DIVZERO_EXC_EN: divZero is held at 0; B=0 runs the full DIV/FIX sequence, and FIX SHALL force HI=A and LO=0xFFFFFFFF.

Verification
REQ-028 Multiply A=0xFFFFFFFD (-3), B=7 → 33 cycles later multStop=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-029 Divide A=-7 (0xFFFFFFF9), B=2 → 34 cycles later divStop=1, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-030 Divide A=5, B=0 → with macro: next cycle divStop=divZero=1 and HI/LO unchanged; without macro: at 34 cycles HI=5, LO=0xFFFFFFFF, divZero=0.
REQ-031 MULT_control and DIV_control both pulsed in IDLE with A=0x00010000, B=0x00010000 → multiply only: HI=1, LO=0, no divStop.
REQ-032 Start a divide, assert reset at cycle 10 → HI=LO=0, no stop pulse; a new multiply 2×3 after reset gives LO=6 at 33 cycles.
REQ-033 DIV_control pulsed during a running multiply → ignored; only multStop fires, and HI/LO hold the product.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if -- control-unit bus for the multiply/divide unit.
//   MULT_control, DIV_control : start requests (sampled by the unit in IDLE only)
//   A, B                      : operands, captured on the start edge
//   HI, LO                    : result (product 63:32 / 31:0, or remainder / quotient)
//   multStop, divStop         : one-cycle completion pulses
//   divZero                   : one-cycle divide-by-zero abort pulse
// Modports: master = control unit, slave = mult_div_unit.
interface mult_div_unit_if;
    logic        MULT_control;
    logic        DIV_control;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        multStop;
    logic        divStop;
    logic        divZero;

    modport master (
        output MULT_control, DIV_control, A, B,
        input  HI, LO, multStop, divStop, divZero
    );

    modport slave (
        input  MULT_control, DIV_control, A, B,
        output HI, LO, multStop, divStop, divZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative 32x32 signed multiply (radix-2 Booth) and signed
// divide (restoring division on magnitudes, sign fix-up afterwards).
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : mult_div_unit_if.slave (requests, operands, HI/LO, stop pulses)
// Fixed latency: multiply stop 33 cycles after the start edge, divide 34.
// Optional feature macro DIVZERO_EXC_EN: when defined, a divide with B=0
// aborts in one cycle with divZero=divStop=1 and HI/LO untouched; when
// undefined, divZero stays 0 and B=0 yields HI=A, LO=0xFFFFFFFF.
//
// state | meaning
// IDLE  | waiting for a request; the only state that samples MULT/DIV_control
// MULT  | one Booth iteration per cycle, 32 cycles
// DIV   | one restoring-division iteration per cycle, 32 cycles
// FIX   | apply quotient/remainder signs (or divide-by-zero result)
// DONE  | publish HI/LO and pulse the matching stop signal
module mult_div_unit (
    input  logic              clk,
    input  logic              reset,
    mult_div_unit_if.slave    bus
);
    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [64:0] r_acc;      // {partial product high, multiplier, Booth q-1}
    logic [31:0] r_opa;      // multiplicand, or original dividend for B=0
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dsr;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_is_div;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_mult_stop;
    logic        r_div_stop;
`ifdef DIVZERO_EXC_EN
    logic        r_zero_req;
    logic        r_div_zero;
`endif

    logic        w_last;
    logic [32:0] w_upper;
    logic [32:0] w_addend;
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic [31:0] w_diff;
    logic        w_ge;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    assign w_last   = (r_cnt == 5'd31);
    assign w_abs_a  = bus.A[31] ? (32'd0 - bus.A) : bus.A;
    assign w_abs_b  = bus.B[31] ? (32'd0 - bus.B) : bus.B;

    // Booth step on a 33-bit upper slice so the most negative multiplicand
    // cannot overflow before the arithmetic shift.
    assign w_upper  = {r_acc[64], r_acc[64:33]};
    assign w_addend = {r_opa[31], r_opa};
    always_comb begin
        w_sum = w_upper;
        case (r_acc[1:0])
            2'b01:   w_sum = w_upper + w_addend;
            2'b10:   w_sum = w_upper - w_addend;
            default: w_sum = w_upper;
        endcase
    end

    // Restoring step: when the shifted remainder is >= divisor the true
    // difference fits in 32 bits, so only the low word is kept.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_ge    = (w_shift >= {1'b0, r_dsr});
    assign w_diff  = w_shift[31:0] - r_dsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.MULT_control) begin
                    w_next = S_MULT;
                end else if (bus.DIV_control) begin
`ifdef DIVZERO_EXC_EN
                    w_next = (bus.B == 32'd0) ? S_DONE : S_DIV;
`else
                    w_next = S_DIV;
`endif
                end
            end
            S_MULT:  if (w_last) w_next = S_DONE;
            S_DIV:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opa       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dsr       <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_is_div    <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_mult_stop <= 1'b0;
            r_div_stop  <= 1'b0;
`ifdef DIVZERO_EXC_EN
            r_zero_req  <= 1'b0;
            r_div_zero  <= 1'b0;
`endif
        end else begin
            r_mult_stop <= 1'b0;
            r_div_stop  <= 1'b0;
`ifdef DIVZERO_EXC_EN
            r_div_zero  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.MULT_control) begin
                        r_acc    <= {32'd0, bus.B, 1'b0};
                        r_opa    <= bus.A;
                        r_cnt    <= '0;
                        r_is_div <= 1'b0;
                    end else if (bus.DIV_control) begin
                        r_opa    <= bus.A;
                        r_quo    <= w_abs_a;
                        r_dsr    <= w_abs_b;
                        r_rem    <= '0;
                        r_sign_a <= bus.A[31];
                        r_sign_b <= bus.B[31];
                        r_cnt    <= '0;
                        r_is_div <= 1'b1;
`ifdef DIVZERO_EXC_EN
                        r_zero_req <= (bus.B == 32'd0);
`endif
                    end
                end
                S_MULT: begin
                    r_acc <= {w_sum, r_acc[32:1]};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff : w_shift[31:0];
                    r_quo <= {r_quo[30:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    if (r_dsr == 32'd0) begin
                        r_rem <= r_opa;
                        r_quo <= 32'hFFFF_FFFF;
                    end else begin
                        r_quo <= (r_sign_a ^ r_sign_b) ? (32'd0 - r_quo) : r_quo;
                        r_rem <= r_sign_a ? (32'd0 - r_rem) : r_rem;
                    end
                end
                S_DONE: begin
                    if (r_is_div) begin
`ifdef DIVZERO_EXC_EN
                        if (r_zero_req) begin
                            r_div_zero <= 1'b1;
                        end else begin
                            r_hi <= r_rem;
                            r_lo <= r_quo;
                        end
`else
                        r_hi <= r_rem;
                        r_lo <= r_quo;
`endif
                        r_div_stop <= 1'b1;
                    end else begin
                        r_hi        <= r_acc[64:33];
                        r_lo        <= r_acc[32:1];
                        r_mult_stop <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;
    assign bus.multStop = r_mult_stop;
    assign bus.divStop  = r_div_stop;
`ifdef DIVZERO_EXC_EN
    assign bus.divZero  = r_div_zero;
`else
    assign bus.divZero  = 1'b0;
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit -- randomized self-checking bench for mult_div_unit.
// Expected results come from plain signed 64-bit arithmetic in the bench.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit_if mdi ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mdi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Runs one operation and checks latency, flags, result and HI/LO hold.
    // poke > 0 pulses DIV_control for one cycle that many cycles after start.
    task automatic do_op(input string tag, input bit m, input bit d,
                         input logic [31:0] a, input logic [31:0] b, input int poke);
        longint      sa, sb, p, q, r;
        logic [31:0] ehi, elo;
        int          elat, lat;
        bit          ediv, ezero, held_ok;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ezero = 1'b0;
        if (m) begin
            p    = sa * sb;
            ehi  = p[63:32];
            elo  = p[31:0];
            elat = 33;
            ediv = 1'b0;
        end else begin
            ediv = 1'b1;
            if (b == 32'd0) begin
`ifdef DIVZERO_EXC_EN
                ehi   = exp_hi;
                elo   = exp_lo;
                elat  = 1;
                ezero = 1'b1;
`else
                ehi  = a;
                elo  = 32'hFFFF_FFFF;
                elat = 34;
`endif
            end else begin
                q    = sa / sb;
                r    = sa % sb;
                ehi  = r[31:0];
                elo  = q[31:0];
                elat = 34;
            end
        end
        @(negedge clk);
        mdi.A = a;
        mdi.B = b;
        mdi.MULT_control = m;
        mdi.DIV_control  = d;
        @(posedge clk);
        #1;
        mdi.MULT_control = 1'b0;
        mdi.DIV_control  = 1'b0;
        mdi.A = $urandom;
        mdi.B = $urandom;
        lat = 0;
        held_ok = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (mdi.multStop || mdi.divStop || mdi.divZero) begin
                lat = i;
                break;
            end
            if (mdi.HI !== exp_hi || mdi.LO !== exp_lo) held_ok = 1'b0;
            if (poke > 0 && i == poke)          mdi.DIV_control = 1'b1;
            else if (poke > 0 && i == poke + 1) mdi.DIV_control = 1'b0;
        end
        mdi.DIV_control = 1'b0;
        chk({tag, "/latency"}, 64'(lat), 64'(elat));
        chk({tag, "/hold"}, 64'(held_ok), 64'd1);
        chk({tag, "/stops"}, {61'd0, mdi.multStop, mdi.divStop, mdi.divZero},
            {61'd0, ~ediv, ediv, ezero});
        chk({tag, "/HI"}, 64'(mdi.HI), 64'(ehi));
        chk({tag, "/LO"}, 64'(mdi.LO), 64'(elo));
        exp_hi = ehi;
        exp_lo = elo;
        @(posedge clk);
        #1;
        chk({tag, "/pulse"}, {61'd0, mdi.multStop, mdi.divStop, mdi.divZero}, 64'd0);
    endtask

    initial begin
        int  lat1, lat2;
        bit  quiet;
        reset = 1'b1;
        mdi.MULT_control = 1'b0;
        mdi.DIV_control  = 1'b0;
        mdi.A = '0;
        mdi.B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/HI", 64'(mdi.HI), 64'd0);
        chk("reset/LO", 64'(mdi.LO), 64'd0);
        chk("reset/stops", {61'd0, mdi.multStop, mdi.divStop, mdi.divZero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op("mul_m3x7", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 0);
        do_op("div_m7d2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("div_5d0", 1'b0, 1'b1, 32'd5, 32'd0, 0);
        do_op("both_req", 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 0);
        do_op("div_wrap", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("mul_minmin", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("mul_ignore_div", 1'b1, 1'b0, 32'd1234, 32'hFFFF_0001, 5);

        // Reset ten cycles into a divide: everything clears, no stop pulse,
        // and a multiply issued on the first edge after release completes.
        @(negedge clk);
        mdi.A = 32'd100;
        mdi.B = 32'd7;
        mdi.DIV_control = 1'b1;
        @(posedge clk);
        #1;
        mdi.DIV_control = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("midreset/HI", 64'(mdi.HI), 64'd0);
        chk("midreset/LO", 64'(mdi.LO), 64'd0);
        chk("midreset/stops", {61'd0, mdi.multStop, mdi.divStop, mdi.divZero}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        do_op("after_reset_2x3", 1'b1, 1'b0, 32'd2, 32'd3, 0);

        // Request held through DONE->IDLE restarts on the first IDLE edge.
        @(negedge clk);
        mdi.A = 32'd9;
        mdi.B = 32'hFFFF_FFFB;
        mdi.MULT_control = 1'b1;
        @(posedge clk);
        lat1 = 0;
        lat2 = 0;
        for (int i = 1; i <= 90; i++) begin
            @(posedge clk);
            #1;
            if (i == 34) mdi.MULT_control = 1'b0;
            if (mdi.multStop) begin
                if (lat1 == 0) lat1 = i;
                else begin
                    lat2 = i;
                    break;
                end
            end
        end
        mdi.MULT_control = 1'b0;
        chk("held/first", 64'(lat1), 64'd33);
        chk("held/second", 64'(lat2), 64'd67);
        chk("held/LO", 64'(mdi.LO), 64'hFFFF_FFFF_FFFF_FFD3 & 64'hFFFF_FFFF);
        chk("held/HI", 64'(mdi.HI), 64'hFFFF_FFFF);
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFD3;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (mdi.multStop || mdi.divStop) quiet = 1'b0;
        end
        chk("held/no_third", 64'(quiet), 64'd1);

        for (int k = 0; k < 24; k++) begin
            bit is_mul;
            is_mul = 1'($urandom_range(0, 1));
            do_op(is_mul ? "rnd_mul" : "rnd_div", is_mul, ~is_mul, rnd_opnd(), rnd_opnd(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
